// File: rtl/ysyx_23060203_ifu_pkg.sv
// Shared IFU types: prediction modes, RV32 opcode fields, immediate decoders, queue entry.
// Latency: n/a (types and pure functions). Backpressure: n/a.
// Users: fetch queue top and its FIFO.
package ysyx_23060203_ifu_pkg;

    typedef enum logic [1:0] {
        PRED_NONE     = 2'd0,
        PRED_BTFN     = 2'd1,
        PRED_BTFN_JAL = 2'd2
    } pred_mode_t;

    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
    } fq_entry_t;

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ysyx_23060203_fetch_fifo.sv
// Synchronous FIFO with clear; head read straight out of the storage flops.
// Latency: push visible at head one cycle later. Backpressure: push accepted when not full or popping.
// Clear empties the queue; reset also zeroes storage so the head reads zero.
module ysyx_23060203_fetch_fifo #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  T                         push_dat,
    input  logic                     pop,
    output T                         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           pop_ok;
    logic           push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= push_dat;
                wptr      <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            if (push_ok & ~pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok & ~push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head_dat = mem[rptr];

endmodule

// File: rtl/ysyx_23060203_ifu_fq.sv
// Instruction fetch unit with static next-PC prediction feeding a fetch queue toward decode.
// Latency: I-cache hit in cycle t appears at the queue head in t+1. Backpressure: full queue holds ic_addr.
// Flush drops the queue; a redirect during an outstanding miss is parked until that miss returns.
module ysyx_23060203_ifu_fq
    import ysyx_23060203_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter int          QDEPTH    = 4,
    parameter int          PRED_MODE = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [31:0]                 dnpc,
    input  logic                        fencei,
    output logic [31:0]                 ic_addr,
    input  logic                        ic_hit,
    input  logic [31:0]                 ic_inst,
    output logic                        ic_fencei,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [31:0]                 out_pc,
    output logic [31:0]                 out_inst,
    output logic                        out_pred_taken,
    output logic [$clog2(QDEPTH):0]     q_count
);
    localparam bit BR_EN  = (PRED_MODE >= int'(PRED_BTFN));
    localparam bit JAL_EN = (PRED_MODE == int'(PRED_BTFN_JAL));

    logic [31:0] fetch_pc;
    logic [31:0] redir_pc;
    logic [31:0] pred_pc;
    logic        redir_pend;
    logic        miss_inflight;
    logic        is_br;
    logic        is_jal;
    logic        pred_taken;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    fq_entry_t   push_dat;
    fq_entry_t   head_dat;

    // Backward conditional branches are predicted taken (sign bit of imm_b is inst[31]).
    assign is_br      = BR_EN && (ic_inst[6:2] == OPC_BRANCH) && ic_inst[31];
    assign is_jal     = JAL_EN && (ic_inst[6:2] == OPC_JAL);
    assign pred_taken = is_br | is_jal;

    always_comb begin
        pred_pc = fetch_pc + 32'd4;
        if (is_br) begin
            pred_pc = fetch_pc + imm_b(ic_inst);
        end else if (is_jal) begin
            pred_pc = fetch_pc + imm_j(ic_inst);
        end
    end

    assign out_valid = ~empty & ~flush;
    assign pop       = out_valid & out_ready;
    assign push      = ic_hit & ~redir_pend & ~flush & (~full | pop);
    assign push_dat  = '{pc: fetch_pc, inst: ic_inst, taken: pred_taken};

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc      <= RESET_PC;
            redir_pc      <= '0;
            redir_pend    <= 1'b0;
            miss_inflight <= 1'b0;
        end else begin
            miss_inflight <= ~ic_hit;
            if (flush) begin
                // The cache may only see a new address once no miss is outstanding.
                if (ic_hit | ~miss_inflight) begin
                    fetch_pc      <= dnpc;
                    redir_pend    <= 1'b0;
                    miss_inflight <= 1'b0;
                end else begin
                    redir_pc   <= dnpc;
                    redir_pend <= 1'b1;
                end
            end else if (ic_hit & redir_pend) begin
                fetch_pc   <= redir_pc;
                redir_pend <= 1'b0;
            end else if (push) begin
                fetch_pc <= pred_pc;
            end
        end
    end

    ysyx_23060203_fetch_fifo #(
        .T     (fq_entry_t),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (flush),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty),
        .count    (q_count)
    );

    assign ic_addr        = fetch_pc;
    assign ic_fencei      = fencei;
    assign out_pc         = head_dat.pc;
    assign out_inst       = head_dat.inst;
    assign out_pred_taken = head_dat.taken;

`ifndef SYNTHESIS
    logic [31:0] perf_ifu_inst;
    logic [31:0] perf_ifu_wait;
    logic [31:0] perf_ifu_hold;

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_ifu_inst <= '0;
            perf_ifu_wait <= '0;
            perf_ifu_hold <= '0;
        end else begin
            if (pop)          perf_ifu_inst <= perf_ifu_inst + 32'd1;
            if (~ic_hit)      perf_ifu_wait <= perf_ifu_wait + 32'd1;
            if (full & ~pop)  perf_ifu_hold <= perf_ifu_hold + 32'd1;
        end
    end
`endif

endmodule
